// File: rtl/tick_divider_if.sv
// tick_divider_if: control/divisor inputs and tick/square/pending outputs of tick_divider; i_sync_in exists only with TICK_DIVIDER_SYNC_EN
interface tick_divider_if #(parameter int CNT_W = 16);
  logic             i_en;
  logic             i_load;
  logic [CNT_W-1:0] i_div_fast_in;
  logic [CNT_W-1:0] i_div_slow_in;
`ifdef TICK_DIVIDER_SYNC_EN
  logic             i_sync_in;
`endif
  logic             o_tick_fast;
  logic             o_tick_slow;
  logic             o_sq_fast;
  logic             o_sq_slow;
  logic             o_pending;
  modport master (
`ifdef TICK_DIVIDER_SYNC_EN
    output i_sync_in,
`endif
    output i_en, i_load, i_div_fast_in, i_div_slow_in,
    input  o_tick_fast, o_tick_slow, o_sq_fast, o_sq_slow, o_pending
  );
  modport slave (
`ifdef TICK_DIVIDER_SYNC_EN
    input  i_sync_in,
`endif
    input  i_en, i_load, i_div_fast_in, i_div_slow_in,
    output o_tick_fast, o_tick_slow, o_sq_fast, o_sq_slow, o_pending
  );
endinterface

// File: rtl/tick_divider.sv
// tick_divider: cascaded fast/slow tick-enable + 50% square-wave divider with shadowed runtime divisors (ports clk, rst, bus: i_en/i_load/i_div_*_in -> o_tick_*/o_sq_*/o_pending; TICK_DIVIDER_SYNC_EN adds i_sync_in counter re-sync)
module tick_divider #(
  parameter int CNT_W    = 16,
  parameter int DIV_FAST = 256,
  parameter int DIV_SLOW = 49
) (
  input logic          clk,
  input logic          rst,
  tick_divider_if.slave bus
);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] RST_F = CNT_W'(DIV_FAST);
  localparam logic [CNT_W-1:0] RST_S = CNT_W'(DIV_SLOW);
  logic [CNT_W-1:0] r_cnt_f, r_cnt_s, r_div_f, r_div_s, r_sh_f, r_sh_s;
  logic             r_tick_f, r_tick_s, r_sq_f, r_sq_s, r_pending;
  logic [CNT_W-1:0] w_ld_f, w_ld_s;
  logic             w_wrap_f, w_wrap_s, w_sync;
  assign w_ld_f   = bus.i_div_fast_in == '0 ? ONE : bus.i_div_fast_in;
  assign w_ld_s   = bus.i_div_slow_in == '0 ? ONE : bus.i_div_slow_in;
  assign w_wrap_f = bus.i_en && r_cnt_f >= r_div_f - ONE;
  assign w_wrap_s = w_wrap_f && r_cnt_s >= r_div_s - ONE;
`ifdef TICK_DIVIDER_SYNC_EN
  logic r_sync, r_sync_d;
  always_ff @(posedge clk)
    if (rst) begin
      r_sync   <= 1'b0;
      r_sync_d <= 1'b0;
    end else begin
      r_sync   <= bus.i_sync_in;
      r_sync_d <= r_sync;
    end
  assign w_sync = r_sync && !r_sync_d;
`else
  assign w_sync = 1'b0;
`endif
  always_ff @(posedge clk)
    if (rst) begin
      r_cnt_f   <= '0;
      r_cnt_s   <= '0;
      r_div_f   <= RST_F;
      r_div_s   <= RST_S;
      r_sh_f    <= RST_F;
      r_sh_s    <= RST_S;
      r_tick_f  <= 1'b0;
      r_tick_s  <= 1'b0;
      r_sq_f    <= 1'b0;
      r_sq_s    <= 1'b0;
      r_pending <= 1'b0;
    end else if (w_sync) begin
      r_cnt_f   <= '0;
      r_cnt_s   <= '0;
      r_div_f   <= r_sh_f;
      r_div_s   <= r_sh_s;
      r_tick_f  <= 1'b0;
      r_tick_s  <= 1'b0;
      r_sq_f    <= 1'b0;
      r_sq_s    <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      r_tick_f <= w_wrap_f;
      r_tick_s <= w_wrap_s;
      r_cnt_f  <= w_wrap_f ? '0 : bus.i_en ? r_cnt_f + ONE : r_cnt_f;
      r_cnt_s  <= w_wrap_s ? '0 : w_wrap_f ? r_cnt_s + ONE : r_cnt_s;
      r_sq_f   <= r_sq_f ^ w_wrap_f;
      r_sq_s   <= r_sq_s ^ w_wrap_s;
      // a load landing on a wrap keeps the old divisors; the new ones wait for the next wrap
      if (bus.i_load) begin
        r_sh_f    <= w_ld_f;
        r_sh_s    <= w_ld_s;
        r_pending <= 1'b1;
      end else if (w_wrap_f) begin
        r_div_f   <= r_sh_f;
        r_div_s   <= r_sh_s;
        r_pending <= 1'b0;
      end
    end
  assign bus.o_tick_fast = r_tick_f;
  assign bus.o_tick_slow = r_tick_s;
  assign bus.o_sq_fast   = r_sq_f;
  assign bus.o_sq_slow   = r_sq_s;
  assign bus.o_pending   = r_pending;
endmodule

// File: tb/tb_tick_divider.sv
// tb_tick_divider: directed plus random stimulus against a cycle-level reference model of tick_divider
module tb_tick_divider;
  localparam int W  = 16;
  localparam int DF = 4;
  localparam int DS = 3;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  tick_divider_if #(.CNT_W(W)) bus ();
  tick_divider #(.CNT_W(W), .DIV_FAST(DF), .DIV_SLOW(DS)) dut (.clk(clk), .rst(rst), .bus(bus));
`ifdef TICK_DIVIDER_SYNC_EN
  initial bus.i_sync_in = 1'b0;
`endif
  int checks = 0;
  int errors = 0;
  int m_cf, m_cs, m_df, m_ds, s_df, s_ds;
  bit m_pend, m_tf, m_ts, m_sf, m_ss;
  int n_tf, n_ts;
  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic step(input bit r, input bit e, input bit l, input int df, input int ds);
    bit wf, ws;
    rst               = r;
    bus.i_en          = e;
    bus.i_load        = l;
    bus.i_div_fast_in = W'(df);
    bus.i_div_slow_in = W'(ds);
    if (r) begin
      m_cf = 0; m_cs = 0; m_df = DF; m_ds = DS; s_df = DF; s_ds = DS;
      m_pend = 0; m_tf = 0; m_ts = 0; m_sf = 0; m_ss = 0;
    end else begin
      wf = e && (m_cf + 1 >= m_df);
      ws = wf && (m_cs + 1 >= m_ds);
      m_cf = wf ? 0 : (e ? m_cf + 1 : m_cf);
      m_cs = ws ? 0 : (wf ? m_cs + 1 : m_cs);
      if (l) begin
        s_df = (df == 0) ? 1 : df;
        s_ds = (ds == 0) ? 1 : ds;
        m_pend = 1;
      end else if (wf && m_pend) begin
        m_df = s_df;
        m_ds = s_ds;
        m_pend = 0;
      end
      m_tf = wf;
      m_ts = ws;
      m_sf = m_sf ^ wf;
      m_ss = m_ss ^ ws;
    end
    @(posedge clk);
    #1;
    chk("tick_fast", bus.o_tick_fast, m_tf);
    chk("tick_slow", bus.o_tick_slow, m_ts);
    chk("sq_fast", bus.o_sq_fast, m_sf);
    chk("sq_slow", bus.o_sq_slow, m_ss);
    chk("pending", bus.o_pending, m_pend);
    chk("slow_implies_fast", bus.o_tick_slow && !bus.o_tick_fast, 1'b0);
    n_tf += int'(bus.o_tick_fast);
    n_ts += int'(bus.o_tick_slow);
  endtask
  initial begin
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    n_tf = 0;
    n_ts = 0;
    for (int i = 0; i < 12; i++) step(0, 1, 0, 0, 0);
    chk_int("fast_ticks_in_12", n_tf, 3);
    chk_int("slow_ticks_in_12", n_ts, 1);
    chk("sq_slow_after_12", bus.o_sq_slow, 1'b1);
    step(1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 1, 2, DS);
    chk("pending_after_load", bus.o_pending, 1'b1);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("old_wrap_c4", bus.o_tick_fast, 1'b1);
    chk("pending_clr_c4", bus.o_pending, 1'b0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("new_wrap_c6", bus.o_tick_fast, 1'b1);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0);
    step(0, 1, 1, 2, 1);
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 0);
    step(0, 1, 1, 0, 1);
    for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 0);
    step(0, 1, 1, 5, 2);
    for (int i = 0; i < 7; i++) step(0, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, i == 4, 3, 4);
    for (int i = 0; i < 20; i++) step(0, 1, 0, 0, 0);
    step(0, 1, 1, 6, 5);
    step(1, 1, 0, 0, 0);
    chk("rst_pending", bus.o_pending, 1'b0);
    for (int i = 0; i < 12; i++) step(0, 1, 0, 0, 0);
    for (int i = 0; i < 4000; i++)
      step($urandom_range(0, 499) == 0, $urandom_range(0, 9) != 0, $urandom_range(0, 29) == 0,
           $urandom_range(0, 6), $urandom_range(0, 4));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
